// File: rtl/i2c_bus_arbiter_if.sv
// Requester-side and LL-driver-side signals of the two-requester I2C arbiter.
// The arbiter uses the slave view; requesters and the LL driver use the master view.
interface i2c_bus_arbiter_if #(
   parameter int MAX_BYTES = 6
);
   localparam int NB_W = $clog2(MAX_BYTES + 2);
   localparam int DW   = 8 * MAX_BYTES;

   logic [1:0]      req;
   logic [6:0]      dev_addr0, dev_addr1;
   logic [7:0]      reg_addr0, reg_addr1;
   logic [NB_W-1:0] num_bytes0, num_bytes1;
   logic            write0, write1;
   logic [DW-1:0]   wdata0, wdata1;
   logic [1:0]      gnt, done, err;
   logic [DW-1:0]   rdata;
   logic            busy;

   logic            ll_disable;
   logic [6:0]      ll_dev_addr;
   logic [7:0]      ll_reg_addr;
   logic [NB_W-1:0] ll_num_bytes;
   logic            ll_write;
   logic [DW-1:0]   ll_wdata;
   logic            ll_done;
   logic [DW-1:0]   ll_rdata;

   modport slave (
      input  req, dev_addr0, dev_addr1, reg_addr0, reg_addr1,
             num_bytes0, num_bytes1, write0, write1, wdata0, wdata1,
             ll_done, ll_rdata,
      output gnt, done, err, rdata, busy,
             ll_disable, ll_dev_addr, ll_reg_addr, ll_num_bytes, ll_write, ll_wdata
   );

   modport master (
      output req, dev_addr0, dev_addr1, reg_addr0, reg_addr1,
             num_bytes0, num_bytes1, write0, write1, wdata0, wdata1,
             ll_done, ll_rdata,
      input  gnt, done, err, rdata, busy,
             ll_disable, ll_dev_addr, ll_reg_addr, ll_num_bytes, ll_write, ll_wdata
   );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C low-level driver between two requesters;
// launches one captured command at a time and returns done/err/rdata.
module i2c_bus_arbiter #(
   parameter int MAX_BYTES      = 6,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input logic                clk_i,
   input logic                rst_ni,
   i2c_bus_arbiter_if.slave   arb_if
);
   localparam int NB_W  = $clog2(MAX_BYTES + 2);
   localparam int DW    = 8 * MAX_BYTES;
   localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [NB_W-1:0]  MAX_NB   = NB_W'(MAX_BYTES);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_FINISH} state_e;

   state_e          state_q, state_d;
   logic [1:0]      gnt_q, gnt_d;
   logic            last_q, last_d;
   logic            errf_q, errf_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic [6:0]      dev_q, dev_d;
   logic [7:0]      reg_q, reg_d;
   logic [NB_W-1:0] nb_q, nb_d;
   logic            wr_q, wr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic            win;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         gnt_q   <= '0;
         last_q  <= 1'b1;
         errf_q  <= 1'b0;
         timer_q <= '0;
         rdata_q <= '0;
         dev_q   <= '0;
         reg_q   <= '0;
         nb_q    <= '0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         errf_q  <= errf_d;
         timer_q <= timer_d;
         rdata_q <= rdata_d;
         dev_q   <= dev_d;
         reg_q   <= reg_d;
         nb_q    <= nb_d;
         wr_q    <= wr_d;
         wdata_q <= wdata_d;
      end
   end

   // On a tie the requester that did not win last time goes first.
   assign win = (arb_if.req == 2'b11) ? ~last_q : arb_if.req[1];

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      errf_d  = errf_q;
      timer_d = timer_q;
      rdata_d = rdata_q;
      dev_d   = dev_q;
      reg_d   = reg_q;
      nb_d    = nb_q;
      wr_d    = wr_q;
      wdata_d = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (|arb_if.req) begin
               gnt_d   = win ? 2'b10 : 2'b01;
               dev_d   = win ? arb_if.dev_addr1  : arb_if.dev_addr0;
               reg_d   = win ? arb_if.reg_addr1  : arb_if.reg_addr0;
               nb_d    = win ? arb_if.num_bytes1 : arb_if.num_bytes0;
               wr_d    = win ? arb_if.write1     : arb_if.write0;
               wdata_d = win ? arb_if.wdata1     : arb_if.wdata0;
               errf_d  = (nb_d > MAX_NB);
               state_d = (nb_d > MAX_NB) ? S_FINISH : S_LOAD;
            end
         end
         S_LOAD: begin
            timer_d = '0;
            state_d = S_RUN;
         end
         S_RUN: begin
            // A completion on the final timer cycle still counts as success.
            if (arb_if.ll_done) begin
               if (!wr_q) rdata_d = arb_if.ll_rdata;
               state_d = S_FINISH;
            end else if (timer_q == TMR_LAST) begin
               errf_d  = 1'b1;
               state_d = S_FINISH;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         S_FINISH: begin
            gnt_d   = '0;
            last_d  = gnt_q[1];
            errf_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign arb_if.gnt          = gnt_q;
   assign arb_if.done         = (state_q == S_FINISH) ? gnt_q : 2'b00;
   assign arb_if.err          = (state_q == S_FINISH && errf_q) ? gnt_q : 2'b00;
   assign arb_if.rdata        = rdata_q;
   assign arb_if.busy         = (state_q != S_IDLE);
   assign arb_if.ll_disable   = !(state_q == S_LOAD || state_q == S_RUN);
   assign arb_if.ll_dev_addr  = dev_q;
   assign arb_if.ll_reg_addr  = reg_q;
   assign arb_if.ll_num_bytes = nb_q;
   assign arb_if.ll_write     = wr_q;
   assign arb_if.ll_wdata     = wdata_q;
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter: reset, read, timeout, reset abort,
// bad length, round-robin fairness and command stability.
module tb_i2c_bus_arbiter;
   localparam int MAX_BYTES = 6;
   localparam int TMO       = 16;
   localparam int DW        = 8 * MAX_BYTES;

   logic clk;
   logic rst_n;
   int   vecs;
   int   miss;
   logic [DW-1:0] exp_rdata;

   i2c_bus_arbiter_if #(.MAX_BYTES(MAX_BYTES)) bus ();

   i2c_bus_arbiter #(.MAX_BYTES(MAX_BYTES), .TIMEOUT_CYCLES(TMO)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .arb_if (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.req = 2'b00;
      bus.dev_addr0 = '0; bus.dev_addr1 = '0;
      bus.reg_addr0 = '0; bus.reg_addr1 = '0;
      bus.num_bytes0 = '0; bus.num_bytes1 = '0;
      bus.write0 = 1'b0; bus.write1 = 1'b0;
      bus.wdata0 = '0; bus.wdata1 = '0;
      bus.ll_done = 1'b0; bus.ll_rdata = '0;
      tick(); tick();
      vecs++;
      if ({bus.gnt, bus.done, bus.err, bus.busy, bus.ll_disable} !== 8'b00_00_00_0_1) begin
         miss++;
         $display("FAIL reset_ctrl: got gnt/done/err/busy/dis=%b want 00000001",
                  {bus.gnt, bus.done, bus.err, bus.busy, bus.ll_disable});
      end
      vecs++;
      if ({bus.ll_dev_addr, bus.ll_reg_addr, bus.ll_num_bytes, bus.ll_write, bus.ll_wdata, bus.rdata} !== '0) begin
         miss++;
         $display("FAIL reset_cmd: got dev=%h reg=%h nb=%0d wr=%b wdata=%h rdata=%h want all zero",
                  bus.ll_dev_addr, bus.ll_reg_addr, bus.ll_num_bytes, bus.ll_write, bus.ll_wdata, bus.rdata);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_read();
      bus.dev_addr0 = 7'h52; bus.reg_addr0 = 8'h00; bus.num_bytes0 = 3'd6; bus.write0 = 1'b0;
      bus.req = 2'b01;
      #1;
      vecs++;
      if ({bus.busy, bus.ll_disable} !== 2'b01) begin
         miss++;
         $display("FAIL read_pre_capture: got busy/dis=%b want 01", {bus.busy, bus.ll_disable});
      end
      tick();
      vecs++;
      if ({bus.gnt, bus.busy, bus.ll_disable} !== 4'b01_1_0) begin
         miss++;
         $display("FAIL read_load: got gnt/busy/dis=%b want 0110", {bus.gnt, bus.busy, bus.ll_disable});
      end
      vecs++;
      if ({bus.ll_dev_addr, bus.ll_reg_addr, bus.ll_num_bytes, bus.ll_write} !== {7'h52, 8'h00, 3'd6, 1'b0}) begin
         miss++;
         $display("FAIL read_cmd: got dev=%h reg=%h nb=%0d wr=%b want 52 00 6 0",
                  bus.ll_dev_addr, bus.ll_reg_addr, bus.ll_num_bytes, bus.ll_write);
      end
      for (int k = 0; k < 10; k++) tick();
      vecs++;
      if ({bus.done, bus.ll_disable} !== 3'b00_0) begin
         miss++;
         $display("FAIL read_run: got done/dis=%b want 000", {bus.done, bus.ll_disable});
      end
      bus.ll_done = 1'b1;
      bus.ll_rdata = 48'h0A0B0C0D0E0F;
      tick();
      bus.ll_done = 1'b0;
      bus.ll_rdata = '0;
      exp_rdata = 48'h0A0B0C0D0E0F;
      vecs++;
      if ({bus.done, bus.err, bus.ll_disable, bus.rdata} !== {2'b01, 2'b00, 1'b1, exp_rdata}) begin
         miss++;
         $display("FAIL read_finish: got done=%b err=%b dis=%b rdata=%h want 01 00 1 %h",
                  bus.done, bus.err, bus.ll_disable, bus.rdata, exp_rdata);
      end
      bus.req = 2'b00;
      tick();
      vecs++;
      if ({bus.done, bus.gnt, bus.busy} !== 5'b0) begin
         miss++;
         $display("FAIL read_idle: got done/gnt/busy=%b want 00000", {bus.done, bus.gnt, bus.busy});
      end
   endtask

   task automatic test_timeout();
      bus.num_bytes0 = 3'd2; bus.write0 = 1'b0;
      bus.req = 2'b01;
      tick();
      for (int k = 0; k < TMO; k++) begin
         tick();
         vecs++;
         if ({bus.done, bus.ll_disable, bus.busy} !== 4'b00_0_1) begin
            miss++;
            $display("FAIL timeout_run%0d: got done/dis/busy=%b want 0001", k, {bus.done, bus.ll_disable, bus.busy});
         end
      end
      tick();
      vecs++;
      if ({bus.done, bus.err, bus.ll_disable, bus.rdata} !== {2'b01, 2'b01, 1'b1, exp_rdata}) begin
         miss++;
         $display("FAIL timeout_finish: got done=%b err=%b dis=%b rdata=%h want 01 01 1 %h",
                  bus.done, bus.err, bus.ll_disable, bus.rdata, exp_rdata);
      end
      bus.req = 2'b00;
      tick();
      vecs++;
      if ({bus.done, bus.err, bus.busy} !== 5'b0) begin
         miss++;
         $display("FAIL timeout_idle: got done/err/busy=%b want 00000", {bus.done, bus.err, bus.busy});
      end
   endtask

   task automatic test_reset_mid_run();
      bus.dev_addr1 = 7'h3C; bus.num_bytes1 = 3'd3; bus.write1 = 1'b0;
      bus.req = 2'b10;
      tick(); tick(); tick();
      vecs++;
      if ({bus.gnt, bus.ll_disable} !== 3'b10_0) begin
         miss++;
         $display("FAIL rstrun_pre: got gnt/dis=%b want 100", {bus.gnt, bus.ll_disable});
      end
      #2;
      rst_n = 1'b0;
      bus.req = 2'b00;
      #1;
      vecs++;
      if ({bus.gnt, bus.busy, bus.ll_disable, bus.rdata} !== {2'b00, 1'b0, 1'b1, 48'h0}) begin
         miss++;
         $display("FAIL rstrun_async: got gnt=%b busy=%b dis=%b rdata=%h want 00 0 1 0",
                  bus.gnt, bus.busy, bus.ll_disable, bus.rdata);
      end
      exp_rdata = '0;
      tick();
      rst_n = 1'b1;
      bus.ll_done = 1'b1;
      bus.ll_rdata = 48'h111111111111;
      tick();
      bus.ll_done = 1'b0;
      vecs++;
      if ({bus.done, bus.busy, bus.rdata} !== {2'b00, 1'b0, 48'h0}) begin
         miss++;
         $display("FAIL rstrun_late_done: got done=%b busy=%b rdata=%h want 00 0 0",
                  bus.done, bus.busy, bus.rdata);
      end
      tick();
      vecs++;
      if (bus.done !== 2'b00) begin
         miss++;
         $display("FAIL rstrun_late_done2: got done=%b want 00", bus.done);
      end
   endtask

   task automatic test_bad_length();
      bus.num_bytes1 = 3'd7; bus.write1 = 1'b1;
      bus.req = 2'b10;
      tick();
      vecs++;
      if ({bus.gnt, bus.done, bus.err, bus.ll_disable} !== 7'b10_10_10_1) begin
         miss++;
         $display("FAIL badlen_finish: got gnt/done/err/dis=%b want 1010101",
                  {bus.gnt, bus.done, bus.err, bus.ll_disable});
      end
      bus.req = 2'b00;
      tick();
      vecs++;
      if ({bus.done, bus.err, bus.busy, bus.ll_disable} !== 6'b00_00_0_1) begin
         miss++;
         $display("FAIL badlen_idle: got done/err/busy/dis=%b want 000001",
                  {bus.done, bus.err, bus.busy, bus.ll_disable});
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] eg;
      logic [6:0] ed;
      logic [7:0] ew;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      bus.dev_addr0 = 7'h11; bus.num_bytes0 = 3'd1; bus.write0 = 1'b1; bus.wdata0 = 48'hA5;
      bus.dev_addr1 = 7'h22; bus.num_bytes1 = 3'd1; bus.write1 = 1'b1; bus.wdata1 = 48'h5A;
      bus.req = 2'b11;
      for (int i = 0; i < 4; i++) begin
         eg = (i % 2 == 0) ? 2'b01 : 2'b10;
         ed = (i % 2 == 0) ? 7'h11 : 7'h22;
         ew = (i % 2 == 0) ? 8'hA5 : 8'h5A;
         tick();
         vecs++;
         if ({bus.gnt, bus.ll_dev_addr, bus.ll_wdata[7:0], bus.ll_disable} !== {eg, ed, ew, 1'b0}) begin
            miss++;
            $display("FAIL rr_grant%0d: got gnt=%b dev=%h wdata=%h dis=%b want %b %h %h 0",
                     i, bus.gnt, bus.ll_dev_addr, bus.ll_wdata[7:0], bus.ll_disable, eg, ed, ew);
         end
         tick();
         bus.ll_done = 1'b1;
         tick();
         bus.ll_done = 1'b0;
         vecs++;
         if ({bus.done, bus.err} !== {eg, 2'b00}) begin
            miss++;
            $display("FAIL rr_done%0d: got done=%b err=%b want %b 00", i, bus.done, bus.err, eg);
         end
         tick();
         vecs++;
         if ({bus.gnt, bus.busy, bus.ll_disable} !== 4'b00_0_1) begin
            miss++;
            $display("FAIL rr_idle%0d: got gnt/busy/dis=%b want 0001", i, {bus.gnt, bus.busy, bus.ll_disable});
         end
      end
      bus.req = 2'b00;
      tick();
      vecs++;
      if (bus.busy !== 1'b0) begin
         miss++;
         $display("FAIL rr_end: got busy=%b want 0", bus.busy);
      end
   endtask

   task automatic test_cmd_stability();
      bus.dev_addr0 = 7'h29; bus.num_bytes0 = 3'd1; bus.write0 = 1'b1; bus.wdata0 = 48'h55;
      bus.req = 2'b01;
      tick();
      tick();
      bus.wdata0 = 48'hAA;
      bus.dev_addr0 = 7'h7F;
      for (int k = 0; k < 3; k++) begin
         tick();
         vecs++;
         if ({bus.ll_wdata, bus.ll_dev_addr} !== {48'h55, 7'h29}) begin
            miss++;
            $display("FAIL stable_run%0d: got wdata=%h dev=%h want 55 29", k, bus.ll_wdata, bus.ll_dev_addr);
         end
      end
      bus.ll_done = 1'b1;
      bus.ll_rdata = 48'hDEADBEEF0123;
      tick();
      bus.ll_done = 1'b0;
      vecs++;
      if ({bus.done, bus.ll_wdata, bus.rdata} !== {2'b01, 48'h55, exp_rdata}) begin
         miss++;
         $display("FAIL stable_finish: got done=%b wdata=%h rdata=%h want 01 55 %h",
                  bus.done, bus.ll_wdata, bus.rdata, exp_rdata);
      end
      bus.req = 2'b00;
      tick();
   endtask

   initial begin
      vecs = 0;
      miss = 0;
      exp_rdata = '0;
      test_reset();
      test_single_read();
      test_timeout();
      test_reset_mid_run();
      test_bad_length();
      test_back_to_back();
      test_cmd_stability();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end
endmodule
